// File: rtl/pulse_decoder_pkg.sv
// rtl/pulse_decoder_pkg.sv - shared state enum, counter width and code decode for pulse_decoder
package pulse_decoder_pkg;

    localparam int CNT_W = 8;

    // Prefixed so the state literals cannot collide with the HOLD/GAP parameters.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] line;
        case (code)
            2'd0:    line = 4'b0001;
            2'd1:    line = 4'b0010;
            2'd2:    line = 4'b0100;
            default: line = 4'b1000;
        endcase
        return line;
    endfunction

endpackage

// File: rtl/pulse_hold_counter.sv
// rtl/pulse_hold_counter.sv - loadable non-wrapping down-counter timing HOLD and GAP windows
module pulse_hold_counter
    import pulse_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_decoder.sv
// rtl/pulse_decoder.sv - registered 2-to-4 pulse decoder; PULSE_DECODER_HITCNT_EN adds hit_count
module pulse_decoder
    import pulse_decoder_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       A1,
    input  logic       A0,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       D3,
    output logic       D2,
    output logic       D1,
    output logic       D0,
    output logic       busy,
    output logic       done
`ifdef PULSE_DECODER_HITCNT_EN
    ,
    output logic [7:0] hit_count
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam bit               GAP_EN  = (GAP > 0);

    state_t           state;
    logic [3:0]       d_line;
    logic             rst_q;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // rst_q keeps in_ready low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign in_ready = EN && !rst && !rst_q &&
                      (state == ST_IDLE || (state == ST_HOLD && cnt_zero && !GAP_EN));
    assign accept   = in_valid && in_ready;

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (!EN) begin
            cnt_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_load = accept;
                    cnt_val  = HOLD_LD;
                end
                ST_HOLD: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (GAP_EN) begin
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LD;
                    end else begin
                        cnt_load = accept;
                        cnt_val  = HOLD_LD;
                    end
                end
                default: cnt_dec = 1'b1;
            endcase
        end
    end

    pulse_hold_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // done is registered one cycle ahead so it lands on the last D-high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            d_line <= 4'b0000;
            done   <= 1'b0;
        end else if (!EN) begin
            state  <= ST_IDLE;
            d_line <= 4'b0000;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state  <= ST_HOLD;
                        d_line <= decode_onehot({A1, A0});
                        done   <= (HOLD == 1);
                    end
                end
                ST_HOLD: begin
                    if (!cnt_zero) begin
                        done <= (cnt == CNT_W'(1));
                    end else if (GAP_EN) begin
                        state  <= ST_GAP;
                        d_line <= 4'b0000;
                        done   <= 1'b0;
                    end else if (accept) begin
                        d_line <= decode_onehot({A1, A0});
                        done   <= (HOLD == 1);
                    end else begin
                        state  <= ST_IDLE;
                        d_line <= 4'b0000;
                        done   <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign {D3, D2, D1, D0} = d_line;
    assign busy = (state != ST_IDLE);

`ifdef PULSE_DECODER_HITCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= 8'd0;
        end else if (done && hit_count != 8'hFF) begin
            hit_count <= hit_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_decoder.sv
// tb/tb_pulse_decoder.sv - directed self-checking bench for pulse_decoder
module tb_pulse_decoder;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic a1, a0, in_valid;
    logic b_a1, b_a0, b_valid;
    logic in_ready, d3, d2, d1, d0, busy, done;
    logic b_ready, b_d3, b_d2, b_d1, b_d0, b_busy, b_done;
`ifdef PULSE_DECODER_HITCNT_EN
    logic [7:0] hit_count;
    logic [7:0] b_hit_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_decoder #(.HOLD(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .EN(en), .A1(a1), .A0(a0),
        .in_valid(in_valid), .in_ready(in_ready),
        .D3(d3), .D2(d2), .D1(d1), .D0(d0), .busy(busy), .done(done)
`ifdef PULSE_DECODER_HITCNT_EN
        , .hit_count(hit_count)
`endif
    );

    pulse_decoder #(.HOLD(2), .GAP(0)) dut_b2b (
        .clk(clk), .rst(rst), .EN(en), .A1(b_a1), .A0(b_a0),
        .in_valid(b_valid), .in_ready(b_ready),
        .D3(b_d3), .D2(b_d2), .D1(b_d1), .D0(b_d0), .busy(b_busy), .done(b_done)
`ifdef PULSE_DECODER_HITCNT_EN
        , .hit_count(b_hit_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one code on the HOLD=4/GAP=1 instance and walk the 6-cycle window.
    task automatic run_pulse(input logic [1:0] code, input logic [3:0] exp_d);
        a1 = code[1];
        a0 = code[0];
        in_valid = 1'b1;
        #1;
        check("pulse_ready_before", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("pulse%0d_d_c%0d", code, k), 32'({d3, d2, d1, d0}),
                  (k <= 4) ? 32'(exp_d) : 32'd0);
            check($sformatf("pulse%0d_done_c%0d", code, k), 32'(done), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("pulse%0d_busy_c%0d", code, k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
            check($sformatf("pulse%0d_ready_c%0d", code, k), 32'(in_ready), (k == 6) ? 32'd1 : 32'd0);
            if (k < 6) step();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        a1 = 1'b0; a0 = 1'b0; in_valid = 1'b0;
        b_a1 = 1'b0; b_a0 = 1'b0; b_valid = 1'b0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_d", 32'({d3, d2, d1, d0}), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_ready", 32'(in_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("release_ready_first", 32'(in_ready), 32'd0);
        step();
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_d", 32'({d3, d2, d1, d0}), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
`ifdef PULSE_DECODER_HITCNT_EN
        check("hit_after_rst", 32'(hit_count), 32'd0);
`endif

        // single decode, then sweep
        run_pulse(2'd2, 4'b0100);
        run_pulse(2'd0, 4'b0001);
        run_pulse(2'd1, 4'b0010);
        run_pulse(2'd3, 4'b1000);

        // back-to-back on HOLD=2/GAP=0 instance
        b_a1 = 1'b0; b_a0 = 1'b1; b_valid = 1'b1;
        #1;
        check("b2b_ready0", 32'(b_ready), 32'd1);
        step();
        b_a1 = 1'b1; b_a0 = 1'b1;
        #1;
        check("b2b_c1_d", 32'({b_d3, b_d2, b_d1, b_d0}), 32'b0010);
        check("b2b_c1_done", 32'(b_done), 32'd0);
        check("b2b_c1_ready", 32'(b_ready), 32'd0);
        step();
        check("b2b_c2_d", 32'({b_d3, b_d2, b_d1, b_d0}), 32'b0010);
        check("b2b_c2_done", 32'(b_done), 32'd1);
        check("b2b_c2_ready", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        check("b2b_c3_d", 32'({b_d3, b_d2, b_d1, b_d0}), 32'b1000);
        check("b2b_c3_done", 32'(b_done), 32'd0);
        check("b2b_c3_busy", 32'(b_busy), 32'd1);
        step();
        check("b2b_c4_d", 32'({b_d3, b_d2, b_d1, b_d0}), 32'b1000);
        check("b2b_c4_done", 32'(b_done), 32'd1);
        step();
        check("b2b_c5_d", 32'({b_d3, b_d2, b_d1, b_d0}), 32'd0);
        check("b2b_c5_busy", 32'(b_busy), 32'd0);

        // abort: EN low in 2nd HOLD cycle of code 0
        a1 = 1'b0; a0 = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("abort_c1_d", 32'({d3, d2, d1, d0}), 32'b0001);
        step();
        check("abort_c2_d", 32'({d3, d2, d1, d0}), 32'b0001);
        en = 1'b0;
        step();
        a1 = 1'b1; a0 = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("abort_d", 32'({d3, d2, d1, d0}), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        en = 1'b1;
        step();
        check("abort_no_queue_d", 32'({d3, d2, d1, d0}), 32'd0);
        check("abort_no_queue_busy", 32'(busy), 32'd0);
        check("abort_ready_back", 32'(in_ready), 32'd1);
`ifdef PULSE_DECODER_HITCNT_EN
        check("hit_after_abort", 32'(hit_count), 32'd4);
`endif

        // rst mid-pulse
        a1 = 1'b0; a0 = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("midrst_pre_d", 32'({d3, d2, d1, d0}), 32'b0010);
        rst = 1'b1;
        step();
        check("midrst_d", 32'({d3, d2, d1, d0}), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        step();
        check("midrst_ready", 32'(in_ready), 32'd1);

`ifdef PULSE_DECODER_HITCNT_EN
        check("hit_midrst", 32'(hit_count), 32'd0);
        a1 = 1'b1; a0 = 1'b0; in_valid = 1'b1;
        repeat (260 * 6) step();
        in_valid = 1'b0;
        repeat (8) step();
        check("hit_saturate", 32'(hit_count), 32'd255);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hit_rst_clear", 32'(hit_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
